// File: rtl/f_mux_sweeper_pkg.sv
// Shared types and constants for the f_MUX sweeper: FSM state encoding and the
// reference truth table of the 3-input f_MUX block.
package f_mux_sweeper_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Expected s indexed by {a,b,c}, a is the MSB.
  localparam logic [7:0] F_MUX_TRUTH = 8'hA5;

  localparam logic [2:0] LastIdx = 3'd7;

endpackage

// File: rtl/f_mux_sweeper_settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; times the settle gap between
// driving a vector and sampling the checked block's output.
module f_mux_sweeper_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/f_mux_sweeper.sv
// Clocked stimulus generator and checker for the 3-input f_MUX block: sweeps all
// eight {a,b,c} vectors, samples s after a settle gap and reports the mismatches.
module f_mux_sweeper
  import f_mux_sweeper_pkg::*;
#(
  parameter logic [7:0]  EXPECTED = F_MUX_TRUTH,
  parameter int unsigned SETTLE   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] err_map
);

  localparam bit         HasSettle  = (SETTLE > 0);
  // The timer is reloaded with SETTLE-1 so that its zero flag marks the last settle cycle.
  localparam logic [3:0] SettleLoad = HasSettle ? 4'(SETTLE - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] abc_q, abc_d;
  logic [3:0] err_count_q, err_count_d;
  logic [7:0] err_map_q, err_map_d;
  logic       pass_q, pass_d;
  logic       timer_load, timer_dec, timer_zero;

  f_mux_sweeper_settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (SettleLoad),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    abc_d       = abc_q;
    err_count_d = err_count_q;
    err_map_d   = err_map_q;
    pass_d      = pass_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StDrive;
          idx_d       = 3'd0;
          abc_d       = 3'd0;
          err_count_d = 4'd0;
          err_map_d   = 8'h00;
          pass_d      = 1'b0;
        end
      end
      StDrive: begin
        timer_load = 1'b1;
        state_d    = HasSettle ? StSettle : StSample;
      end
      StSettle: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (s != EXPECTED[idx_q]) begin
          err_map_d[idx_q] = 1'b1;
          err_count_d      = err_count_q + 4'd1;
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
          abc_d   = 3'd0;
          pass_d  = (err_count_d == 4'd0);
        end else begin
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_d;
          state_d = StDrive;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      abc_q       <= 3'd0;
      err_count_q <= 4'd0;
      err_map_q   <= 8'h00;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      abc_q       <= abc_d;
      err_count_q <= err_count_d;
      err_map_q   <= err_map_d;
      pass_q      <= pass_d;
    end
  end

  assign {a, b, c}  = abc_q;
  assign busy       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign err_map    = err_map_q;

endmodule

// File: tb/tb_f_mux_sweeper.sv
// Scoreboard bench for f_mux_sweeper: three instances (SETTLE 0, 1, 3) share a clock
// and reset; expected reports are queued at start and checked whenever done pulses.
module tb_f_mux_sweeper;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  map;
    logic [3:0]  cnt;
    logic        pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [1:0] smode;  // 0: real f_MUX, 1: s tied 0, 2: s tied 1
  logic [2:0] a, b, c, s, busy, done, pass;
  logic [3:0] cnt [3];
  logic [7:0] map [3];
  logic [7:0] truth = 8'hA5;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errs = 0;
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (smode)
        2'd0:    s[i] = truth[{a[i], b[i], c[i]}];
        2'd1:    s[i] = 1'b0;
        default: s[i] = 1'b1;
      endcase
    end
  end

  f_mux_sweeper #(.SETTLE(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .s(s[0]), .a(a[0]), .b(b[0]), .c(c[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(cnt[0]), .err_map(map[0])
  );
  f_mux_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .s(s[1]), .a(a[1]), .b(b[1]), .c(c[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(cnt[1]), .err_map(map[1])
  );
  f_mux_sweeper #(.SETTLE(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .s(s[2]), .a(a[2]), .b(b[2]), .c(c[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(cnt[2]), .err_map(map[2])
  );

  function automatic int unsigned sweep_len(input int i);
    int unsigned st;
    st = (i == 0) ? 0 : (i == 1) ? 1 : 3;
    return 8 * (2 + st);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d at edge %0d: got 0x%0h, expected 0x%0h", name, i, cyc, act, exp);
    end
  endtask

  function automatic int pending();
    return q0.size() + q1.size() + q2.size();
  endfunction

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic check_done(input int i);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errs++;
      $display("FAIL unexpected_done dut%0d at edge %0d: got done=1, expected no result", i, cyc);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk("done_edge", i, cyc, e.edge_no);
      chk("err_map", i, map[i], e.map);
      chk("err_count", i, cnt[i], e.cnt);
      chk("pass", i, pass[i], e.pass);
      chk("abc_in_done", i, {a[i], b[i], c[i]}, 0);
      chk("busy_in_done", i, busy[i], 0);
    end
  endtask

  // Monitor: pops one expected report per done pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) check_done(i);
    end
  end

  task automatic drain();
    int k = 0;
    while (pending() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (pending() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d reports outstanding, expected 0", pending());
      flush();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] mask, input logic [7:0] m, input logic [3:0] n,
                       input logic p, output int unsigned acc);
    exp_t e;
    acc = cyc + 1;
    start = mask;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        e.edge_no = acc + sweep_len(i);
        e.map = m;
        e.cnt = n;
        e.pass = p;
        push(i, e);
      end
    end
  endtask

  task automatic sweep(input logic [2:0] mask, input logic [1:0] mode, input logic [7:0] m,
                       input logic [3:0] n, input logic p);
    int unsigned acc;
    @(negedge clk);
    smode = mode;
    issue(mask, m, n, p, acc);
    @(negedge clk);
    start = 3'b000;
    drain();
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 3; i++) begin
      chk("reset_outputs", i,
          {a[i], b[i], c[i], busy[i], done[i], pass[i], cnt[i], map[i]}, 0);
    end
  endtask

  int unsigned acc;

  initial begin
    reset = 1'b1;
    start = 3'b000;
    smode = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // Real f_MUX: done at edges 16, 24, 40 for SETTLE 0, 1, 3.
    sweep(3'b111, 2'd0, 8'h00, 4'd0, 1'b1);
    sweep(3'b111, 2'd1, 8'hA5, 4'd4, 1'b0);
    sweep(3'b111, 2'd2, 8'h5A, 4'd4, 1'b0);

    // Results hold in IDLE.
    repeat (5) @(negedge clk);
    chk("hold_err_map", 1, map[1], 8'h5A);
    chk("hold_err_count", 1, cnt[1], 4'd4);
    chk("hold_busy", 1, busy[1], 0);

    // Vector order on the SETTLE=1 instance: vector k sampled after edge acc+3k+2.
    @(negedge clk);
    smode = 2'd0;
    issue(3'b010, 8'h00, 4'd0, 1'b1, acc);
    @(negedge clk);
    start = 3'b000;
    for (int k = 0; k < 8; k++) begin
      while (cyc < acc + 3 * k + 2) @(negedge clk);
      chk("vector_order", 1, {a[1], b[1], c[1]}, k);
      chk("busy_in_sweep", 1, busy[1], 1);
    end
    drain();

    // Start held: accepts at acc, acc+26, acc+52; busy low only in DONE and IDLE.
    @(negedge clk);
    smode = 2'd0;
    issue(3'b010, 8'h00, 4'd0, 1'b1, acc);
    begin
      exp_t e;
      e.map = 8'h00;
      e.cnt = 4'd0;
      e.pass = 1'b1;
      e.edge_no = acc + 50;
      push(1, e);
      e.edge_no = acc + 76;
      push(1, e);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("held_busy", 1, busy[1], ((k % 26) < 24) ? 1 : 0);
    end
    start = 3'b000;
    drain();

    // Reset at edge 10 of a sweep aborts with no report.
    @(negedge clk);
    smode = 2'd1;
    issue(3'b111, 8'hA5, 4'd4, 1'b0, acc);
    @(negedge clk);
    start = 3'b000;
    while (cyc < acc + 10) @(negedge clk);
    chk("pre_reset_err_count", 1, cnt[1], 4'd2);
    chk("pre_reset_abc", 1, {a[1], b[1], c[1]}, 3'd3);
    #1 reset = 1'b1;
    #1 check_reset_state();
    flush();
    @(negedge clk);
    reset = 1'b0;
    sweep(3'b111, 2'd0, 8'h00, 4'd0, 1'b1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
